// File: rtl/meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and the
// saturation limit of the interval counter.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    localparam int DEFAULT_WORD_LENGTH = 16;

    // Largest count a WORD_LENGTH-bit counter can hold before it saturates.
    function automatic logic [31:0] count_max(input int word_length);
        return (32'd1 << word_length) - 32'd1;
    endfunction

endpackage

// File: rtl/period_meter_rise_detect.sv
// Single-cycle rising-edge pulse from a level that is already synchronous to clock_i.
// The history register resets high so a level held high through reset is not an edge.
module rise_detect (
    input  logic clock_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/period_meter.sv
// Measures clock cycles between successive rising edges of tick_i and hands each
// interval to a consumer; every edge closes one interval and opens the next.
module period_meter
    import meter_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   tick_i,
    input  logic                   ready_i,
    output logic [WORD_LENGTH-1:0] period_o,
    output logic                   valid_o,
    output logic                   overflow_o,
    output logic                   dropped_o,
    output meter_state_t           state_o
);

    localparam logic [WORD_LENGTH-1:0] COUNT_MAX  = WORD_LENGTH'(count_max(WORD_LENGTH));
    localparam logic [WORD_LENGTH-1:0] COUNT_NEAR = COUNT_MAX - WORD_LENGTH'(1);
    localparam logic [WORD_LENGTH-1:0] COUNT_ONE  = WORD_LENGTH'(1);

    meter_state_t           state_q, state_d;
    logic [WORD_LENGTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;
    logic [WORD_LENGTH-1:0] period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   drop_q, drop_d;
    logic                   rise;
    logic                   capture;

    rise_detect u_rise_detect (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .level_i (tick_i),
        .rise_o  (rise)
    );

    // Handshake: a result transfers in any cycle where valid_o and ready_i are both
    // high; while valid_o is high and unaccepted, period_o/overflow_o do not change
    // and a freshly captured result is thrown away (flagged on dropped_o).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sat_d    = sat_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        capture  = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            count_d = '0;
            sat_d   = 1'b0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    count_d = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        count_d = COUNT_ONE;
                        sat_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        capture = 1'b1;
                        count_d = COUNT_ONE;
                        sat_d   = 1'b0;
                    end else begin
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + COUNT_ONE;
                        end
                        // Flag as soon as the count reaches its ceiling, so an
                        // interval of exactly COUNT_MAX also reports overflow.
                        if (count_q >= COUNT_NEAR) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (capture) begin
                if (!valid_q || ready_i) begin
                    period_d = count_q;
                    ovf_d    = sat_q;
                    valid_d  = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sat_q    <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign period_o   = period_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
    assign dropped_o  = drop_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a 16-bit and an 8-bit instance share stimulus and are
// both compared every cycle against an edge-timestamp reference model.
module tb_period_meter;
    import meter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic tick = 1'b0;
    logic rdy  = 1'b0;

    logic [15:0]  p16;
    logic         v16, o16, d16;
    meter_state_t s16;
    logic [7:0]   p8;
    logic         v8, o8, d8;
    meter_state_t s8;

    period_meter #(.WORD_LENGTH(16)) dut16 (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .tick_i(tick), .ready_i(rdy),
        .period_o(p16), .valid_o(v16), .overflow_o(o16), .dropped_o(d16), .state_o(s16)
    );

    period_meter #(.WORD_LENGTH(8)) dut8 (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .tick_i(tick), .ready_i(rdy),
        .period_o(p8), .valid_o(v8), .overflow_o(o8), .dropped_o(d8), .state_o(s8)
    );

    // Reference model: remembers the cycle of the last counted edge and derives
    // each interval as a timestamp difference, clipped to the counter maximum.
    int   cyc      = 0;
    logic m_prev   = 1'b1;
    int   m_run    = 0;
    bit   m_have   = 1'b0;
    int   m_last   = 0;
    int   m_max[2] = '{65535, 255};
    logic m_valid[2] = '{1'b0, 1'b0};
    int   m_period[2] = '{0, 0};
    logic m_ovf[2]  = '{1'b0, 1'b0};
    logic m_drop[2] = '{1'b0, 1'b0};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic meter_state_t exp_state();
        if (m_run == 0) return IDLE;
        if (!m_have) return ARM;
        return MEASURE;
    endfunction

    task automatic model_step();
        bit rise;
        bit cap;
        int p;
        cap = 1'b0;
        p   = 0;
        if (rst) begin
            m_prev = 1'b1;
            m_run  = 0;
            m_have = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0; m_period[i] = 0; m_ovf[i] = 1'b0; m_drop[i] = 1'b0;
            end
        end else if (!en) begin
            m_prev = tick;
            m_run  = 0;
            m_have = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_drop[i] = 1'b0;
            end
        end else begin
            rise = tick && !m_prev;
            if (m_run > 0 && rise) begin
                if (m_have) begin
                    cap = 1'b1;
                    p   = cyc - m_last;
                end
                m_have = 1'b1;
                m_last = cyc;
            end
            for (int i = 0; i < 2; i++) begin
                if (cap) begin
                    if (!m_valid[i] || rdy) begin
                        m_valid[i]  = 1'b1;
                        m_period[i] = (p >= m_max[i]) ? m_max[i] : p;
                        m_ovf[i]    = (p >= m_max[i]);
                    end else begin
                        m_drop[i] = 1'b1;
                    end
                end else if (m_valid[i] && rdy) begin
                    m_valid[i] = 1'b0;
                end
            end
            m_run++;
            m_prev = tick;
        end
    endtask

    task automatic check_all();
        chk("w16_valid",    v16, m_valid[0]);
        chk("w16_period",   p16, m_period[0]);
        chk("w16_overflow", o16, m_ovf[0]);
        chk("w16_dropped",  d16, m_drop[0]);
        chk("w16_state",    s16, exp_state());
        chk("w8_valid",     v8,  m_valid[1]);
        chk("w8_period",    p8,  m_period[1]);
        chk("w8_overflow",  o8,  m_ovf[1]);
        chk("w8_dropped",   d8,  m_drop[1]);
        chk("w8_state",     s8,  exp_state());
    endtask

    task automatic step(input logic r, input logic e, input logic t, input logic q);
        @(negedge clk);
        rst  = r;
        en   = e;
        tick = t;
        rdy  = q;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        logic r, e, t, q;
        int   n;
        logic v;
        int   p;
        logic o;
        logic d;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic t, input logic q, input int n,
                       input logic v, input int p, input logic o, input logic d);
        vec_t x;
        x.r = r; x.e = e; x.t = t; x.q = q; x.n = n;
        x.v = v; x.p = p; x.o = o; x.d = d;
        tbl.push_back(x);
    endtask

    int n_res;
    int mode;
    int len;
    logic rt;

    initial begin
        // rst en tick rdy cycles | valid period ovf dropped (16-bit instance, after last cycle)
        add(1, 0, 0, 1,  2,  0,   0, 0, 0);
        add(0, 1, 0, 1,  3,  0,   0, 0, 0);
        add(0, 1, 1, 1,  1,  0,   0, 0, 0);
        add(0, 1, 0, 1, 99,  0,   0, 0, 0);
        add(0, 1, 1, 1,  1,  1, 100, 0, 0);
        add(0, 1, 0, 1,  1,  0, 100, 0, 0);
        add(0, 1, 0, 1, 98,  0, 100, 0, 0);
        add(0, 1, 1, 1,  1,  1, 100, 0, 0);
        add(0, 1, 0, 1,  1,  0, 100, 0, 0);
        add(0, 1, 0, 0, 18,  0, 100, 0, 0);
        add(0, 1, 1, 0,  1,  1,  20, 0, 0);
        add(0, 1, 0, 0, 19,  1,  20, 0, 0);
        add(0, 1, 1, 0,  1,  1,  20, 0, 1);
        add(0, 1, 0, 0, 19,  1,  20, 0, 1);
        add(0, 1, 1, 1,  1,  1,  20, 0, 1);
        add(0, 1, 0, 1,  1,  0,  20, 0, 1);
        add(0, 1, 0, 0, 18,  0,  20, 0, 1);
        add(0, 1, 1, 0,  1,  1,  20, 0, 1);
        add(0, 1, 0, 0, 36,  1,  20, 0, 1);
        add(0, 0, 0, 0,  1,  0,  20, 0, 0);
        add(0, 1, 0, 1,  3,  0,  20, 0, 0);
        add(0, 1, 1, 1,  1,  0,  20, 0, 0);
        add(0, 1, 0, 1,  9,  0,  20, 0, 0);
        add(0, 1, 1, 1,  1,  1,  10, 0, 0);
        add(0, 1, 0, 1,  5,  0,  10, 0, 0);
        add(1, 1, 1, 1,  1,  0,   0, 0, 0);
        add(0, 1, 1, 1,  3,  0,   0, 0, 0);
        add(0, 1, 0, 1,  5,  0,   0, 0, 0);
        add(0, 1, 1, 1,  1,  0,   0, 0, 0);
        add(0, 1, 0, 1,  3,  0,   0, 0, 0);
        add(0, 1, 1, 1,  1,  1,   4, 0, 0);

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) begin
                step(tbl[k].r, tbl[k].e, tbl[k].t, tbl[k].q);
            end
            chk("tbl_valid",    v16, tbl[k].v);
            chk("tbl_period",   p16, tbl[k].p);
            chk("tbl_overflow", o16, tbl[k].o);
            chk("tbl_dropped",  d16, tbl[k].d);
        end

        // Minimum period: alternating tick gives a 2-cycle result on every high.
        step(0, 1, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 1, 1);
            chk("minp_valid",  v16, 1);
            chk("minp_period", p16, 2);
            step(0, 1, 0, 1);
        end

        // A tick held high is one edge only.
        n_res = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 1, 1);
            if (v16) n_res++;
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1);
            if (v16) n_res++;
        end
        chk("held_results", n_res, 1);

        // Saturation on the 8-bit instance, then recovery and the exact boundary.
        step(0, 1, 1, 1);
        for (int k = 0; k < 299; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("sat300_w8_period", p8,  255);
        chk("sat300_w8_ovf",    o8,  1);
        chk("sat300_w16_period", p16, 300);
        chk("sat300_w16_ovf",   o16, 0);
        for (int k = 0; k < 49; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("after_sat_period", p8, 50);
        chk("after_sat_ovf",    o8, 0);
        for (int k = 0; k < 254; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("p255_period", p8, 255);
        chk("p255_ovf",    o8, 1);
        for (int k = 0; k < 253; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("p254_period", p8, 254);
        chk("p254_ovf",    o8, 0);

        // Randomised phases: dense, sparse and silent tick patterns with random
        // backpressure and occasional enable drops and resets.
        for (int ph = 0; ph < 30; ph++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(20, 300);
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0:       rt = ($urandom_range(0, 99) < 50);
                    1:       rt = ($urandom_range(0, 99) < 10);
                    2:       rt = ($urandom_range(0, 99) < 2);
                    default: rt = 1'b0;
                endcase
                step(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) != 0),
                     rt, ($urandom_range(0, 3) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
